// File: rtl/seq_pkg.sv
// Shared constants for the 101011 serial link: pattern, counter widths and the
// transmitter FSM encoding. The detector uses the same PATTERN constant.
package seq_pkg;
  localparam int PAT_W = 6;
  localparam logic [PAT_W-1:0] PATTERN = 6'b101011;
  localparam int RPT_W = 4;
  localparam int GAP_W = 3;
  localparam int IDX_W = $clog2(PAT_W);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/seq_pattern_tx_if.sv
// Control and serial-output bundle of the pattern transmitter. The sequencer
// side is master, the transmitter is slave.
interface seq_pattern_tx_if;
  import seq_pkg::*;

  logic             start;
  logic             abort;
  logic [RPT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap_cycles;
  logic             x;
  logic             x_valid;
  logic             pat_sent;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, repeat_cnt, gap_cycles,
    input  x, x_valid, pat_sent, busy, done
  );

  modport slave (
    input  start, abort, repeat_cnt, gap_cycles,
    output x, x_valid, pat_sent, busy, done
  );
endinterface

// File: rtl/pattern_shreg.sv
// Loadable MSB-first shift register for one pattern, with a bit index counter.
// Zero fill means the output bit falls to 0 once the pattern has shifted out.
module pattern_shreg
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic load_i,
  input  logic shift_i,
  output logic bit_o,
  output logic last_o
);

  logic [PAT_W-1:0] sr_q;
  logic [IDX_W-1:0] idx_q;
  logic             last_q;

  // last_q is high exactly while bit 0 of the pattern is on bit_o
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
    end else if (clr_i) begin
      sr_q   <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
    end else if (load_i) begin
      sr_q   <= PATTERN;
      idx_q  <= IDX_W'(PAT_W - 1);
      last_q <= (PAT_W == 1);
    end else if (shift_i) begin
      sr_q   <= {sr_q[PAT_W-2:0], 1'b0};
      last_q <= (idx_q == IDX_W'(1));
      if (idx_q != '0) idx_q <= idx_q - 1'b1;
    end
  end

  assign bit_o  = sr_q[PAT_W-1];
  assign last_o = last_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first repeat_cnt times with an
// optional gap between repeats. All outputs come straight from flops.
//
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | one pattern bit on x per cycle
//   GAP   | idle cycles between repeats, still busy
//   DONE  | one-cycle done pulse, start ignored
module seq_pattern_tx
  import seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  seq_pattern_tx_if.slave tx_if
);

  logic [1:0]       state_q, state_d;
  logic [RPT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             x_valid_q, busy_q, done_q;
  logic             sr_clr, sr_load, sr_shift, sr_bit, sr_last;

  pattern_shreg u_shreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (sr_clr),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .bit_o   (sr_bit),
    .last_o  (sr_last)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    sr_clr    = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    if (tx_if.abort) begin
      state_d   = ST_IDLE;
      rem_d     = '0;
      gap_cnt_d = '0;
      sr_clr    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tx_if.start) begin
            rem_d     = tx_if.repeat_cnt;
            gap_len_d = tx_if.gap_cycles;
            if (tx_if.repeat_cnt != '0) begin
              state_d = ST_SHIFT;
              sr_load = 1'b1;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          if (sr_last) begin
            rem_d = rem_q - 1'b1;
            if (rem_q > RPT_W'(1)) begin
              if (gap_len_q == '0) begin
                sr_load = 1'b1;
              end else begin
                state_d   = ST_GAP;
                gap_cnt_d = gap_len_q;
                sr_shift  = 1'b1;
              end
            end else begin
              state_d  = ST_DONE;
              sr_shift = 1'b1;
            end
          end else begin
            sr_shift = 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_W'(1)) begin
            state_d = ST_SHIFT;
            sr_load = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      x_valid_q <= (state_d == ST_SHIFT);
      busy_q    <= (state_d == ST_SHIFT) || (state_d == ST_GAP);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign tx_if.x        = sr_bit;
  assign tx_if.x_valid  = x_valid_q;
  assign tx_if.pat_sent = sr_last;
  assign tx_if.busy     = busy_q;
  assign tx_if.done     = done_q;

endmodule
